// File: rtl/alu_pkg.sv
// Shared types, opcode encodings and the reference ALU function for alu_cmd_seq.
package alu_pkg;

  typedef enum logic [1:0] {
    MODE_DIS = 2'b00,
    MODE_A   = 2'b01,
    MODE_B   = 2'b10,
    MODE_AB  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  localparam logic [2:0] AOP_ADD  = 3'd0;
  localparam logic [2:0] AOP_SUB  = 3'd1;
  localparam logic [2:0] AOP_XOR  = 3'd2;
  localparam logic [2:0] AOP_AND  = 3'd3;
  localparam logic [2:0] AOP_OR   = 3'd4;
  localparam logic [2:0] AOP_XNOR = 3'd5;

  localparam logic [1:0] BOP_NAND = 2'd0;
  localparam logic [1:0] BOP_ADD  = 2'd1;
  localparam logic [1:0] BOP_NOR  = 2'd2;
  localparam logic [1:0] BOP_SUB  = 2'd3;

  localparam logic [1:0] ABOP_XOR   = 2'd0;
  localparam logic [1:0] ABOP_XNOR  = 2'd1;
  localparam logic [1:0] ABOP_DECA  = 2'd2;
  localparam logic [1:0] ABOP_INCB2 = 2'd3;

  // Operands arrive sign-extended; callers truncate to the ALU result width.
  function automatic logic signed [31:0] alu_expect(mode_e mode, logic [2:0] a_op,
                                                    logic [1:0] b_op,
                                                    logic signed [31:0] a,
                                                    logic signed [31:0] b);
    logic signed [31:0] r;
    r = '0;
    if (mode == MODE_AB) begin
      case (b_op)
        ABOP_XOR:   r = a ^ b;
        ABOP_XNOR:  r = ~(a ^ b);
        ABOP_DECA:  r = a - 32'sd1;
        ABOP_INCB2: r = b + 32'sd2;
        default:    r = '0;
      endcase
    end else if (mode == MODE_A) begin
      case (a_op)
        AOP_ADD:  r = a + b;
        AOP_SUB:  r = a - b;
        AOP_XOR:  r = a ^ b;
        AOP_AND:  r = a & b;
        AOP_OR:   r = a | b;
        AOP_XNOR: r = ~(a ^ b);
        default:  r = '0;
      endcase
    end else if (mode == MODE_B) begin
      case (b_op)
        BOP_NAND: r = ~(a & b);
        BOP_ADD:  r = a + b;
        BOP_NOR:  r = ~(a | b);
        BOP_SUB:  r = a - b;
        default:  r = '0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for alu_cmd_seq; entries hold {mode, op, a, b}, no bypass path.
module alu_cmd_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [2*WIDTH+4:0] push_data,
  input  logic               pop,
  output logic [2*WIDTH+4:0] pop_data,
  output logic               full,
  output logic               empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [2*WIDTH+4:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic               do_push;
  logic               do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_seq.sv
// Command sequencer for a registered ALU: FIFO -> issue -> wait -> response.
// Optional result self-check enabled by defining ALU_CMD_SEQ_CHECK_EN.
module alu_cmd_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic signed [WIDTH-1:0] cmd_a,
  input  logic signed [WIDTH-1:0] cmd_b,
  input  logic [1:0]              cmd_mode,
  input  logic [2:0]              cmd_op,
  output logic signed [WIDTH-1:0] A,
  output logic signed [WIDTH-1:0] B,
  output logic                    ALU_en,
  output logic                    a_en,
  output logic                    b_en,
  output logic [2:0]              a_op,
  output logic [1:0]              b_op,
  input  logic signed [WIDTH:0]   C,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic signed [WIDTH:0]   res_data,
  output logic                    mismatch
);

  localparam int EW = 2*WIDTH + 5;

  state_e            state, state_nxt;
  mode_e             mode_q;
  logic              pop;
  logic              full;
  logic              empty;
  logic [EW-1:0]     pop_data;
  logic [1:0]        pop_mode;
  logic [2:0]        pop_op;
  logic [WIDTH-1:0]  pop_a;
  logic [WIDTH-1:0]  pop_b;

  assign cmd_ready = !full;

  alu_cmd_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cmd_valid),
    .push_data ({cmd_mode, cmd_op, cmd_a, cmd_b}),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty)
  );

  assign {pop_mode, pop_op, pop_a, pop_b} = pop_data;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    ALU_en    = 1'b0;
    a_en      = 1'b0;
    b_en      = 1'b0;
    res_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        ALU_en    = (mode_q != MODE_DIS);
        a_en      = mode_q[0];
        b_en      = mode_q[1];
        state_nxt = ST_WAIT;
      end
      ST_WAIT: state_nxt = ST_RESP;
      ST_RESP: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Drive registers hold their last issued values until the next pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      A        <= '0;
      B        <= '0;
      a_op     <= '0;
      b_op     <= '0;
      mode_q   <= MODE_DIS;
      res_data <= '0;
    end else begin
      if (pop) begin
        A      <= pop_a;
        B      <= pop_b;
        a_op   <= pop_op;
        b_op   <= pop_op[1:0];
        mode_q <= mode_e'(pop_mode);
      end
      if (state == ST_WAIT) res_data <= (mode_q == MODE_DIS) ? '0 : C;
    end
  end

`ifdef ALU_CMD_SEQ_CHECK_EN
  logic signed [WIDTH:0] exp_res;

  assign exp_res = (WIDTH+1)'(alu_expect(mode_q, a_op, b_op, 32'(A), 32'(B)));

  always_ff @(posedge clk) begin
    if (rst)
      mismatch <= 1'b0;
    else if (state == ST_WAIT && mode_q != MODE_DIS && C != exp_res)
      mismatch <= 1'b1;
  end
`else
  assign mismatch = 1'b0;
`endif

endmodule
